// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, functs,
// ULA operation codes and datapath mux selects.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11,
        JAL      = 4'd12,
        JR       = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_JR  = 6'b001000;

    localparam logic [2:0] ULA_AND = 3'b000;
    localparam logic [2:0] ULA_OR  = 3'b001;
    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_NOR = 3'b011;
    localparam logic [2:0] ULA_SUB = 3'b110;
    localparam logic [2:0] ULA_SLT = 3'b111;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ULA    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_A      = 2'b11;

endpackage

// File: rtl/ula_funct_decoder.sv
// R-type funct to ULA operation decode; valid is low for any funct that is not
// an arithmetic/logic R-type (jr is routed separately by the controller).
module ula_funct_decoder
    import mips_mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] ula_control,
    output logic       valid
);

    always_comb begin
        ula_control = ULA_ADD;
        valid       = 1'b1;
        case (funct)
            F_ADD:   ula_control = ULA_ADD;
            F_SUB:   ula_control = ULA_SUB;
            F_AND:   ula_control = ULA_AND;
            F_OR:    ula_control = ULA_OR;
            F_NOR:   ula_control = ULA_NOR;
            F_SLT:   ula_control = ULA_SLT;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Moore FSM sequencing the multicycle MIPS datapath, with memory-ready stalls
// in FETCH, MEMREAD and MEMWRITE.
module mips_multicycle_control #(
    parameter int OPW = 6,
    parameter int FNW = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] op,
    input  logic [FNW-1:0] funct,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           pc_en,
    output logic           pc_write,
    output logic           branch,
    output logic           ior_d,
    output logic           mem_write,
    output logic           ir_write,
    output logic [1:0]     reg_dst,
    output logic [1:0]     mem_to_reg,
    output logic           reg_write,
    output logic           ula_src_a,
    output logic [1:0]     ula_src_b,
    output logic [1:0]     pc_src,
    output logic [2:0]     ula_control,
    output logic           illegal,
    output logic [3:0]     state
);
    import mips_mc_pkg::*;

    state_t     state_q, state_d, dec_next;
    logic [5:0] op6, fn6;
    logic [2:0] dec_ula;
    logic       dec_valid, dec_legal;
    logic       pc_write_c, ir_write_c, reg_write_c, mem_write_c, illegal_c;

    assign op6 = 6'(op);
    assign fn6 = 6'(funct);

    ula_funct_decoder u_dec (
        .funct       (fn6),
        .ula_control (dec_ula),
        .valid       (dec_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        dec_next  = FETCH;
        dec_legal = 1'b1;
        if (op6 == OP_LW || op6 == OP_SW)          dec_next = MEMADR;
        else if (op6 == OP_RTYPE && dec_valid)     dec_next = EXECUTE;
        else if (op6 == OP_RTYPE && fn6 == F_JR)   dec_next = JR;
        else if (op6 == OP_BEQ)                    dec_next = BRANCH;
        else if (op6 == OP_ADDI)                   dec_next = ADDIEX;
        else if (op6 == OP_J)                      dec_next = JUMP;
        else if (op6 == OP_JAL)                    dec_next = JAL;
        else                                       dec_legal = 1'b0;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE:   state_d = dec_next;
            MEMADR:   state_d = (op6 == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
            EXECUTE:  state_d = ALUWB;
            ADDIEX:   state_d = ADDIWB;
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        mem_write_c = 1'b0;
        illegal_c   = 1'b0;
        branch      = 1'b0;
        ior_d       = 1'b0;
        reg_dst     = RD_RT;
        mem_to_reg  = M2R_ALU;
        ula_src_a   = 1'b0;
        ula_src_b   = SRCB_B;
        pc_src      = PCS_ULA;
        ula_control = ULA_AND;
        case (state_q)
            FETCH: begin
                ula_src_b   = SRCB_4;
                ula_control = ULA_ADD;
                ir_write_c  = mem_ready;
                pc_write_c  = mem_ready;
            end
            DECODE: begin
                ula_src_b   = SRCB_IMM_SH;
                ula_control = ULA_ADD;
                illegal_c   = ~dec_legal;
            end
            MEMADR, ADDIEX: begin
                ula_src_a   = 1'b1;
                ula_src_b   = SRCB_IMM;
                ula_control = ULA_ADD;
            end
            MEMREAD:  ior_d = 1'b1;
            MEMWB: begin
                mem_to_reg  = M2R_MDR;
                reg_write_c = 1'b1;
            end
            MEMWRITE: begin
                ior_d       = 1'b1;
                mem_write_c = 1'b1;
            end
            EXECUTE: begin
                ula_src_a   = 1'b1;
                ula_control = dec_ula;
            end
            ALUWB: begin
                reg_dst     = RD_RD;
                reg_write_c = 1'b1;
            end
            BRANCH: begin
                ula_src_a   = 1'b1;
                ula_control = ULA_SUB;
                pc_src      = PCS_ALUOUT;
                branch      = 1'b1;
            end
            ADDIWB:   reg_write_c = 1'b1;
            JUMP: begin
                pc_src     = PCS_JUMP;
                pc_write_c = 1'b1;
            end
            JAL: begin
                pc_src      = PCS_JUMP;
                pc_write_c  = 1'b1;
                reg_dst     = RD_RA;
                mem_to_reg  = M2R_PC;
                reg_write_c = 1'b1;
            end
            JR: begin
                pc_src     = PCS_A;
                pc_write_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are masked by rst_n so nothing writes while reset is held.
    assign pc_write  = pc_write_c & rst_n;
    assign ir_write  = ir_write_c & rst_n;
    assign reg_write = reg_write_c & rst_n;
    assign mem_write = mem_write_c & rst_n;
    assign illegal   = illegal_c & rst_n;
    assign pc_en     = (pc_write_c | (branch & zero)) & rst_n;
    assign state     = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle controller: walks each instruction class
// cycle by cycle and compares state plus every output against hand tables.
module tb_mips_multicycle_control;
    import mips_mc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       pc_en, pc_write, branch, ior_d, mem_write, ir_write;
    logic [1:0] reg_dst, mem_to_reg, ula_src_b, pc_src;
    logic       reg_write, ula_src_a, illegal;
    logic [2:0] ula_control;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    mips_multicycle_control #(.OPW(6), .FNW(6)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .pc_write(pc_write),
        .branch(branch), .ior_d(ior_d), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .ula_src_a(ula_src_a), .ula_src_b(ula_src_b),
        .pc_src(pc_src), .ula_control(ula_control), .illegal(illegal),
        .state(state)
    );

    always #5 clk = ~clk;

    // {pc_en,pc_write,branch,ior_d,mem_write,ir_write}_reg_dst_mem_to_reg_reg_write_srca_srcb_pcsrc_ula_illegal
    wire [19:0] outv = {pc_en, pc_write, branch, ior_d, mem_write, ir_write,
                        reg_dst, mem_to_reg, reg_write, ula_src_a, ula_src_b,
                        pc_src, ula_control, illegal};

    localparam logic [19:0] V_IDLE   = 20'b000000_00_00_0_0_01_00_010_0;
    localparam logic [19:0] V_FETCH  = 20'b110001_00_00_0_0_01_00_010_0;
    localparam logic [19:0] V_DECODE = 20'b000000_00_00_0_0_11_00_010_0;
    localparam logic [19:0] V_ILLEG  = 20'b000000_00_00_0_0_11_00_010_1;
    localparam logic [19:0] V_MEMADR = 20'b000000_00_00_0_1_10_00_010_0;
    localparam logic [19:0] V_MEMRD  = 20'b000100_00_00_0_0_00_00_000_0;
    localparam logic [19:0] V_MEMWB  = 20'b000000_00_01_1_0_00_00_000_0;
    localparam logic [19:0] V_MEMWR  = 20'b000110_00_00_0_0_00_00_000_0;
    localparam logic [19:0] V_EXEC0  = 20'b000000_00_00_0_1_00_00_000_0;
    localparam logic [19:0] V_ALUWB  = 20'b000000_01_00_1_0_00_00_000_0;
    localparam logic [19:0] V_BR_T   = 20'b101000_00_00_0_1_00_01_110_0;
    localparam logic [19:0] V_BR_N   = 20'b001000_00_00_0_1_00_01_110_0;
    localparam logic [19:0] V_ADDIWB = 20'b000000_00_00_1_0_00_00_000_0;
    localparam logic [19:0] V_JUMP   = 20'b110000_00_00_0_0_00_10_000_0;
    localparam logic [19:0] V_JAL    = 20'b110000_10_10_1_0_00_10_000_0;
    localparam logic [19:0] V_JR     = 20'b110000_00_00_0_0_00_11_000_0;

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; op = 6'd0; funct = 6'd0;
        @(negedge clk); #1;
        n_checks++;
        if (state !== 4'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d want 0", state);
        end
        n_checks++;
        if (outv !== V_IDLE) begin
            n_fail++; $display("FAIL reset_outputs: got %b want %b", outv, V_IDLE);
        end
        rst_n = 1'b1; mem_ready = 1'b0; #1;
        n_checks++;
        if (outv !== V_IDLE) begin
            n_fail++; $display("FAIL reset_release_outputs: got %b want %b", outv, V_IDLE);
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fns [6];
        logic [2:0] ulas[6];
        state_t     st  [5];
        logic [19:0] ov [5];
        logic       mr  [5];
        int         rw_cycles;
        fns  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
        ulas = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b011, 3'b111};
        st   = '{FETCH, DECODE, EXECUTE, ALUWB, FETCH};
        mr   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 6; k++) begin
            op = 6'b000000; funct = fns[k]; rw_cycles = 0;
            ov = '{V_FETCH, V_DECODE, V_EXEC0 | {16'd0, ulas[k], 1'b0}, V_ALUWB, V_IDLE};
            for (int i = 0; i < 5; i++) begin
                if (i > 0) @(negedge clk);
                mem_ready = mr[i]; #1;
                if (reg_write === 1'b1) rw_cycles++;
                n_checks++;
                if (state !== st[i]) begin
                    n_fail++; $display("FAIL rtype%0d_state[%0d]: got %0d want %0d", k, i, state, st[i]);
                end
                n_checks++;
                if (outv !== ov[i]) begin
                    n_fail++; $display("FAIL rtype%0d_out[%0d]: got %b want %b", k, i, outv, ov[i]);
                end
            end
            n_checks++;
            if (rw_cycles !== 1) begin
                n_fail++; $display("FAIL rtype%0d_regwrite_cycles: got %0d want 1", k, rw_cycles);
            end
        end
    endtask

    task automatic test_lw_stall();
        state_t      st[8];
        logic [19:0] ov[8];
        logic        mr[8];
        op = 6'b100011; funct = 6'd0;
        st = '{FETCH, DECODE, MEMADR, MEMREAD, MEMREAD, MEMREAD, MEMWB, FETCH};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        ov = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMWB, V_IDLE};
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            mem_ready = mr[i]; #1;
            n_checks++;
            if (state !== st[i]) begin
                n_fail++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, st[i]);
            end
            n_checks++;
            if (outv !== ov[i]) begin
                n_fail++; $display("FAIL lw_out[%0d]: got %b want %b", i, outv, ov[i]);
            end
        end
    endtask

    task automatic test_sw_addi_j();
        logic [5:0]  ops[3];
        state_t      st [3][5];
        logic [19:0] ov [3][5];
        logic        mr [3][5];
        int          len[3];
        ops = '{6'b101011, 6'b001000, 6'b000010};
        len = '{6, 5, 4};
        st[0] = '{FETCH, DECODE, MEMADR, MEMWRITE, MEMWRITE};
        ov[0] = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR, V_MEMWR};
        mr[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        st[1] = '{FETCH, DECODE, ADDIEX, ADDIWB, FETCH};
        ov[1] = '{V_FETCH, V_DECODE, V_MEMADR, V_ADDIWB, V_IDLE};
        mr[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        st[2] = '{FETCH, DECODE, JUMP, FETCH, FETCH};
        ov[2] = '{V_FETCH, V_DECODE, V_JUMP, V_IDLE, V_IDLE};
        mr[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 3; k++) begin
            op = ops[k]; funct = 6'd0;
            for (int i = 0; i < len[k]; i++) begin
                if (i > 0) @(negedge clk);
                if (i < 5) begin
                    mem_ready = mr[k][i]; #1;
                    n_checks++;
                    if (state !== st[k][i]) begin
                        n_fail++; $display("FAIL op%0d_state[%0d]: got %0d want %0d", k, i, state, st[k][i]);
                    end
                    n_checks++;
                    if (outv !== ov[k][i]) begin
                        n_fail++; $display("FAIL op%0d_out[%0d]: got %b want %b", k, i, outv, ov[k][i]);
                    end
                end else begin
                    mem_ready = 1'b0; #1;
                    n_checks++;
                    if (state !== 4'd0 || outv !== V_IDLE) begin
                        n_fail++; $display("FAIL op%0d_end: got state %0d out %b want 0 %b", k, state, outv, V_IDLE);
                    end
                end
            end
        end
    endtask

    task automatic test_beq();
        state_t      st[4];
        logic [19:0] ov[4];
        logic        mr[4];
        st = '{FETCH, DECODE, BRANCH, FETCH};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 2; k++) begin
            op = 6'b000100; funct = 6'd0; zero = (k == 0);
            ov = '{V_FETCH, V_DECODE, (k == 0) ? V_BR_T : V_BR_N, V_IDLE};
            for (int i = 0; i < 4; i++) begin
                if (i > 0) @(negedge clk);
                mem_ready = mr[i]; #1;
                n_checks++;
                if (state !== st[i]) begin
                    n_fail++; $display("FAIL beq_z%0d_state[%0d]: got %0d want %0d", 1 - k, i, state, st[i]);
                end
                n_checks++;
                if (outv !== ov[i]) begin
                    n_fail++; $display("FAIL beq_z%0d_out[%0d]: got %b want %b", 1 - k, i, outv, ov[i]);
                end
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jal_jr();
        state_t      st[7];
        logic [19:0] ov[7];
        logic        mr[7];
        op = 6'b000011; funct = 6'd0;
        st = '{FETCH, DECODE, JAL, FETCH, DECODE, JR, FETCH};
        ov = '{V_FETCH, V_DECODE, V_JAL, V_FETCH, V_DECODE, V_JR, V_IDLE};
        mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 3) begin op = 6'b000000; funct = 6'b001000; end
            mem_ready = mr[i]; #1;
            n_checks++;
            if (state !== st[i]) begin
                n_fail++; $display("FAIL jal_jr_state[%0d]: got %0d want %0d", i, state, st[i]);
            end
            n_checks++;
            if (outv !== ov[i]) begin
                n_fail++; $display("FAIL jal_jr_out[%0d]: got %b want %b", i, outv, ov[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0]  ops[2];
        logic [5:0]  fns[2];
        state_t      st[4];
        logic [19:0] ov[4];
        logic        mr[4];
        ops = '{6'b111111, 6'b000000};
        fns = '{6'b100000, 6'b000000};
        st  = '{FETCH, DECODE, FETCH, FETCH};
        ov  = '{V_FETCH, V_ILLEG, V_IDLE, V_IDLE};
        mr  = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 2; k++) begin
            op = ops[k]; funct = fns[k];
            for (int i = 0; i < 4; i++) begin
                if (i > 0) @(negedge clk);
                mem_ready = mr[i]; #1;
                n_checks++;
                if (state !== st[i]) begin
                    n_fail++; $display("FAIL illegal%0d_state[%0d]: got %0d want %0d", k, i, state, st[i]);
                end
                n_checks++;
                if (outv !== ov[i]) begin
                    n_fail++; $display("FAIL illegal%0d_out[%0d]: got %b want %b", k, i, outv, ov[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        state_t      st[4];
        logic [19:0] ov[4];
        logic        mr[4];
        op = 6'b101011; funct = 6'd0;
        st = '{FETCH, DECODE, MEMADR, MEMWRITE};
        ov = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            mem_ready = mr[i]; #1;
            n_checks++;
            if (state !== st[i] || outv !== ov[i]) begin
                n_fail++; $display("FAIL midrst_pre[%0d]: got state %0d out %b want %0d %b", i, state, outv, st[i], ov[i]);
            end
        end
        rst_n = 1'b0; #1;
        n_checks++;
        if (mem_write !== 1'b0) begin
            n_fail++; $display("FAIL midrst_mem_write: got %b want 0", mem_write);
        end
        n_checks++;
        if (state !== 4'd0 || outv !== V_IDLE) begin
            n_fail++; $display("FAIL midrst_async: got state %0d out %b want 0 %b", state, outv, V_IDLE);
        end
        @(negedge clk); mem_ready = 1'b1; #1;
        n_checks++;
        if (state !== 4'd0 || outv !== V_IDLE) begin
            n_fail++; $display("FAIL midrst_held: got state %0d out %b want 0 %b", state, outv, V_IDLE);
        end
        rst_n = 1'b1; mem_ready = 1'b0; #1;
        @(negedge clk); #1;
        n_checks++;
        if (state !== 4'd0 || outv !== V_IDLE) begin
            n_fail++; $display("FAIL midrst_after: got state %0d out %b want 0 %b", state, outv, V_IDLE);
        end
    endtask

    task automatic test_fetch_stall();
        state_t      st[6];
        logic [19:0] ov[6];
        logic        mr[6];
        op = 6'b000010; funct = 6'd0;
        st = '{FETCH, FETCH, FETCH, DECODE, JUMP, FETCH};
        ov = '{V_IDLE, V_IDLE, V_FETCH, V_DECODE, V_JUMP, V_IDLE};
        mr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            mem_ready = mr[i]; #1;
            n_checks++;
            if (state !== st[i]) begin
                n_fail++; $display("FAIL fstall_state[%0d]: got %0d want %0d", i, state, st[i]);
            end
            n_checks++;
            if (outv !== ov[i]) begin
                n_fail++; $display("FAIL fstall_out[%0d]: got %b want %b", i, outv, ov[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_sw_addi_j();
        test_beq();
        test_jal_jr();
        test_illegal();
        test_reset_midflight();
        test_fetch_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Moore-style FSM that sequences the multicycle MIPS datapath: shared instruction/data memory, IR, MDR, A/B, ALUOut registers, one ULA.
Supports add, sub, and, or, nor, slt, jr, lw, sw, beq, addi, j and jal, using the same opcode/funct and ULAControl encodings as the single-cycle control unit.
Adds a memory-ready handshake so that fetch and data accesses can stall.

Parameters:
OPW, 6, opcode width
FNW, 6, funct width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  OPW  IR[31:26], stable from the end of FETCH
funct  in  FNW  IR[5:0]
zero  in  1  ULA zero flag
mem_ready  in  1  memory has completed the current access this cycle
pc_en  out  1  pc_write | (branch & zero)
pc_write  out  1  unconditional PC write
branch  out  1  beq compare cycle
ior_d  out  1  0 = PC address, 1 = ALUOut address
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
reg_dst  out  2  00 = rt, 01 = rd, 10 = $31
mem_to_reg  out  2  00 = ALUOut, 01 = MDR, 10 = PC
reg_write  out  1  register file write
ula_src_a  out  1  0 = PC, 1 = A
ula_src_b  out  2  00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
pc_src  out  2  00 = ULA result, 01 = ALUOut, 10 = jump target, 11 = A (jr)
ula_control  out  3  010 add, 110 sub, 000 and, 001 or, 011 nor, 111 slt
illegal  out  1  one-cycle pulse on an unsupported op/funct
state  out  4  current state, for debug

Behaviour:
- Reset: rst_n low forces state = FETCH asynchronously. While rst_n = 0, pc_write, ir_write, reg_write, mem_write, pc_en and illegal are forced to 0.
- Outputs are a function of state only. Exceptions:
  - ir_write and pc_write in FETCH are gated by mem_ready.
  - ula_control in EXECUTE comes from funct.
  - pc_en is combinational.
- Any output not listed for a state is 0.
- States, outputs and transitions:
  - FETCH: ior_d = 0, ula_src_a = 0, ula_src_b = 01, ula 010, pc_src = 00, ir_write = pc_write = mem_ready. Go to DECODE when mem_ready = 1, else hold.
  - DECODE: ula_src_a = 0, ula_src_b = 11, ula 010 (branch target into ALUOut). Next state by op:
    - lw or sw → MEMADR
    - op = 000000 with a valid R funct → EXECUTE
    - funct 001000 (jr) → JR
    - beq → BRANCH
    - addi → ADDIEX
    - j → JUMP
    - jal → JAL
    - anything else → FETCH with illegal = 1 for that one cycle
  - MEMADR: ula_src_a = 1, ula_src_b = 10, ula 010. lw → MEMREAD, sw → MEMWRITE.
  - MEMREAD: ior_d = 1. Hold until mem_ready, then → MEMWB.
  - MEMWB: reg_dst = 00, mem_to_reg = 01, reg_write = 1 → FETCH.
  - MEMWRITE: ior_d = 1, mem_write = 1 held until mem_ready, then → FETCH.
  - EXECUTE: ula_src_a = 1, ula_src_b = 00, ula_control decoded from funct → ALUWB.
  - ALUWB: reg_dst = 01, mem_to_reg = 00, reg_write = 1 → FETCH.
  - BRANCH: ula_src_a = 1, ula_src_b = 00, ula 110, pc_src = 01, branch = 1 → FETCH.
  - ADDIEX: ula_src_a = 1, ula_src_b = 10, ula 010 → ADDIWB.
  - ADDIWB: reg_dst = 00, mem_to_reg = 00, reg_write = 1 → FETCH.
  - JUMP: pc_src = 10, pc_write = 1 → FETCH.
  - JAL: pc_src = 10, pc_write = 1, reg_dst = 10, mem_to_reg = 10, reg_write = 1 (writes the already-incremented PC) → FETCH.
  - JR: pc_src = 11, pc_write = 1 → FETCH.
- Latency with mem_ready held at 1, in cycles:
  - 3 cycles: beq, j, jal, jr
  - 4 cycles: R-type, sw, addi
  - 5 cycles: lw
  - Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds 1.
- An unencoded state value returns to FETCH on the next edge.
- Reset asserted mid-instruction aborts it; no partial write is issued after reset.

Decomposition:
- Package mips_mc_pkg holds:
  - state_t enum (4-bit), FETCH = 0
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL
  - funct constants, including F_JR
  - ULA_* codes
  - reg_dst, mem_to_reg, ula_src_b and pc_src select constants
- One sub-module, ula_funct_decoder: combinational funct → {ula_control, valid}, used by EXECUTE and by DECODE legality.

Test Plan:
- Reset, then op = 000000, funct = 100000, mem_ready = 1 → states FETCH, DECODE, EXECUTE, ALUWB, FETCH. ula_control = 010 in EXECUTE; reg_write = 1 and reg_dst = 01 for exactly one cycle.
- lw (100011) with mem_ready low for 2 cycles in MEMREAD → MEMREAD held 3 cycles with ior_d = 1, then MEMWB with mem_to_reg = 01 and reg_write = 1. Total 7 cycles.
- beq (000100): zero = 1 → pc_en = 1 in BRANCH with pc_src = 01. Repeat with zero = 0 → pc_en = 0. Both take 3 cycles.
- jal (000011) → JAL state with pc_write = 1, pc_src = 10, reg_dst = 10, mem_to_reg = 10, reg_write = 1. Then jr (funct 001000) → JR with pc_src = 11.
- op = 111111 → illegal pulses for 1 cycle in DECODE, next state FETCH, no write enables asserted.
- rst_n dropped during MEMWRITE with mem_ready = 0 → mem_write falls to 0 asynchronously; state = FETCH after release. Also check that FETCH with mem_ready = 0 keeps ir_write = pc_write = 0.
